mm_seq_ctrl: RTL and testbench

MM_SEQ_CTRL -- requirements
Module: mm_seq_ctrl

---
 rtl/mm_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_mm_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_seq_ctrl.sv
// mm_seq_ctrl: address and strobe sequencer for an M x K by K x N matrix
// product. Walks the output matrix P row-major, spending K operand-fetch
// cycles (OP) and one write-back cycle (WP) on every element. Mode selects
// whether A is stored K x N (P = X*A) or N x K (P = X*A^T).
module mm_seq_ctrl #(
    parameter int M  = 4,
    parameter int K  = 5,
    parameter int N  = 4,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Start,
    input  logic          mode,
    input  logic          stall,
    output logic          busy,
    output logic          addr_valid,
    output logic          control,
    output logic          result_en,
    output logic          done,
    output logic [AW-1:0] addr_x,
    output logic [AW-1:0] addr_A,
    output logic [AW-1:0] addr_P
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OP   = 2'd1;
    localparam logic [1:0] WP   = 2'd2;

    // Index widths never drop below one bit so a dimension of 1 still works.
    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam int JW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    localparam logic [IW-1:0] I_LAST = IW'(M - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);

    logic [1:0]    state;
    logic [IW-1:0] i;
    logic [JW-1:0] j;
    logic [KW-1:0] k;
    logic          mode_q;

    logic [AW-1:0] x_addr;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] p_addr;

    // Row-major word addresses; arithmetic modulo 2^AW equals the truncated full-precision value.
    always_comb begin
        x_addr = AW'(i) * AW'(K) + AW'(k);
        p_addr = AW'(i) * AW'(N) + AW'(j);
        if (mode_q) begin
            a_addr = AW'(j) * AW'(K) + AW'(k);
        end else begin
            a_addr = AW'(k) * AW'(N) + AW'(j);
        end
    end

    // Sequencer state and loop indices; stall freezes everything outside IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            mode_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        mode_q <= mode;
                        i      <= '0;
                        j      <= '0;
                        k      <= '0;
                        state  <= OP;
                    end
                end
                OP: begin
                    if (!stall) begin
                        if (k == K_LAST) begin
                            k     <= '0;
                            state <= WP;
                        end else begin
                            k <= k + KW'(1);
                        end
                    end
                end
                WP: begin
                    if (!stall) begin
                        if (j == J_LAST) begin
                            j <= '0;
                            if (i == I_LAST) begin
                                i     <= '0;
                                state <= IDLE;
                            end else begin
                                i     <= i + IW'(1);
                                state <= OP;
                            end
                        end else begin
                            j     <= j + JW'(1);
                            state <= OP;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode: everything is zero in IDLE, strobes are masked while stalled.
    always_comb begin
        busy       = 1'b0;
        addr_valid = 1'b0;
        control    = 1'b0;
        result_en  = 1'b0;
        done       = 1'b0;
        addr_x     = '0;
        addr_A     = '0;
        addr_P     = '0;
        case (state)
            OP: begin
                busy       = 1'b1;
                addr_valid = !stall;
                control    = (k != K_LAST);
                addr_x     = x_addr;
                addr_A     = a_addr;
                addr_P     = p_addr;
            end
            WP: begin
                busy      = 1'b1;
                result_en = !stall;
                done      = !stall && (i == I_LAST) && (j == J_LAST);
                addr_P    = p_addr;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// tb_mm_seq_ctrl: scoreboard bench for mm_seq_ctrl. Expected fetches and
// writes are queued when a run is started and popped as the DUT emits them.
module tb_mm_seq_ctrl;

    localparam int M = 4;
    localparam int K = 5;
    localparam int N = 4;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] a;
        logic       c;
    } fetch_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       stall = 1'b0;
    logic       busy, addr_valid, control, result_en, done;
    logic [7:0] addr_x, addr_A, addr_P;

    logic       start2 = 1'b0;
    logic       busy2, addr_valid2, control2, result_en2, done2;
    logic [3:0] addr_x2, addr_A2, addr_P2;

    fetch_t     fetchQ[$];
    logic [7:0] writeQ[$];
    fetch_t     f;
    logic [7:0] w;

    int testCount = 0;
    int failCount = 0;
    int cycleCnt = 0;
    int writeCnt = 0;
    int firstWriteCycle = 0;
    int expDone = 0;
    bit doneSeen = 1'b0;

    mm_seq_ctrl #(.M(M), .K(K), .N(N), .AW(8)) dut (
        .clk(clk), .rst(rst), .Start(start), .mode(mode), .stall(stall),
        .busy(busy), .addr_valid(addr_valid), .control(control),
        .result_en(result_en), .done(done),
        .addr_x(addr_x), .addr_A(addr_A), .addr_P(addr_P)
    );

    mm_seq_ctrl #(.M(2), .K(1), .N(2), .AW(4)) dut2 (
        .clk(clk), .rst(rst), .Start(start2), .mode(1'b0), .stall(1'b0),
        .busy(busy2), .addr_valid(addr_valid2), .control(control2),
        .result_en(result_en2), .done(done2),
        .addr_x(addr_x2), .addr_A(addr_A2), .addr_P(addr_P2)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Queue the full fetch/write sequence of one product and start the DUT.
    task automatic applyStimulus(input logic m, input int stallCycles);
        for (int ii = 0; ii < M; ii++) begin
            for (int jj = 0; jj < N; jj++) begin
                for (int kk = 0; kk < K; kk++) begin
                    fetch_t e;
                    e.x = 8'(ii * K + kk);
                    e.a = m ? 8'(jj * K + kk) : 8'(kk * N + jj);
                    e.c = (kk != K - 1);
                    fetchQ.push_back(e);
                end
                writeQ.push_back(8'(ii * N + jj));
            end
        end
        expDone = M * N * (K + 1) + stallCycles;
        cycleCnt = 0;
        writeCnt = 0;
        firstWriteCycle = 0;
        doneSeen = 1'b0;
        mode = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        int n = 0;
        while (!doneSeen && n < limit) begin
            @(posedge clk);
            n++;
        end
        if (!doneSeen) checkOutput("done_timeout", 32'd0, 32'd1);
        #1;
        checkOutput("write_count", 32'(writeCnt), 32'(M * N));
        checkOutput("fetch_left", 32'(fetchQ.size()), 32'd0);
    endtask

    function automatic logic [31:0] allOutputs();
        return {3'b0, busy, addr_valid, control, result_en, done, addr_x, addr_A, addr_P};
    endfunction

    // Scoreboard monitor: pops expected fetches/writes as the DUT strobes them.
    always @(negedge clk) begin
        if (busy) cycleCnt++;
        if (addr_valid) begin
            if (fetchQ.size() == 0) begin
                checkOutput("fetch_unexpected", 32'd1, 32'd0);
            end else begin
                f = fetchQ.pop_front();
                checkOutput("addr_x", 32'(addr_x), 32'(f.x));
                checkOutput("addr_A", 32'(addr_A), 32'(f.a));
                checkOutput("control", 32'(control), 32'(f.c));
            end
        end
        if (result_en) begin
            if (writeCnt == 0) firstWriteCycle = cycleCnt;
            writeCnt++;
            if (writeQ.size() == 0) begin
                checkOutput("write_unexpected", 32'd1, 32'd0);
            end else begin
                w = writeQ.pop_front();
                checkOutput("addr_P", 32'(addr_P), 32'(w));
            end
        end
        if (done) begin
            doneSeen = 1'b1;
            checkOutput("done_cycle", 32'(cycleCnt), 32'(expDone));
            checkOutput("done_with_write", 32'(result_en), 32'd1);
        end
    end

    // Main stimulus sequence.
    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", allOutputs(), 32'd0);
        checkOutput("reset_outputs_k1", {19'b0, busy2, addr_valid2, control2, result_en2, done2,
                                         addr_x2, addr_A2, addr_P2}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Plain mode-0 run.
        $display("[TB] run: mode 0, no stall");
        applyStimulus(1'b0, 0);
        waitDone(300);
        checkOutput("first_write_cycle", 32'(firstWriteCycle), 32'd6);

        // Back-to-back mode-1 run with a spurious Start and mode toggle mid-run.
        $display("[TB] run: mode 1, back-to-back, Start pulsed mid-run");
        applyStimulus(1'b1, 0);
        repeat (39) @(posedge clk);
        #1;
        start = 1'b1;
        mode = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(300);
        checkOutput("first_write_cycle_m1", 32'(firstWriteCycle), 32'd6);

        // Stall in IDLE must do nothing.
        stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("idle_stall_outputs", allOutputs(), 32'd0);
        end
        @(posedge clk);
        #1;
        stall = 1'b0;

        // Three-cycle stall at k=2 of element 5 (i=1, j=1).
        $display("[TB] run: stall at element 5");
        applyStimulus(1'b0, 3);
        repeat (32) @(posedge clk);
        #1;
        stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("stall_valid", 32'(addr_valid), 32'd0);
            checkOutput("stall_busy", 32'(busy), 32'd1);
            checkOutput("stall_addr_x", 32'(addr_x), 32'd7);
            checkOutput("stall_addr_A", 32'(addr_A), 32'd9);
            checkOutput("stall_addr_P", 32'(addr_P), 32'd5);
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
        waitDone(300);

        // Reset during OP of element 7, then a fresh run.
        $display("[TB] run: reset during element 7");
        applyStimulus(1'b1, 0);
        repeat (43) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("writes_before_rst", 32'(writeCnt), 32'd7);
        fetchQ.delete();
        writeQ.delete();
        @(negedge clk);
        checkOutput("post_rst_outputs", allOutputs(), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 0);
        waitDone(300);

        // Small configuration: M=N=2, K=1.
        $display("[TB] run: M=N=2, K=1");
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            int e;
            bit isWp;
            @(negedge clk);
            e = (c - 1) / 2;
            isWp = (c % 2 == 0);
            checkOutput("k1_control", 32'(control2), 32'd0);
            checkOutput("k1_result_en", 32'(result_en2), isWp ? 32'd1 : 32'd0);
            checkOutput("k1_done", 32'(done2), (c == 8) ? 32'd1 : 32'd0);
            if (isWp) begin
                checkOutput("k1_addr_P", 32'(addr_P2), 32'(e));
            end else begin
                checkOutput("k1_valid", 32'(addr_valid2), 32'd1);
                checkOutput("k1_addr_x", 32'(addr_x2), 32'(e / 2));
                checkOutput("k1_addr_A", 32'(addr_A2), 32'(e % 2));
            end
        end
        @(negedge clk);
        checkOutput("k1_idle_busy", 32'(busy2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
